// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_ctrl
// Brief    : First-word-fall-through FIFO controller wrapped around a
//            single-clock RAM whose registered read port is the output stage.
// Revision : 1.0
// ============================================================================
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_wr_enb,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_enb,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam logic [ADDR_WIDTH:0]   c_FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_ONE_COUNT  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE_PTR    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_count;
    logic                  r_out_valid;

    logic w_push;
    logic w_issue;
    logic w_pop;
    logic [ADDR_WIDTH:0] w_ram_count_nxt;

    // A read is issued only from words committed at an earlier edge, and no
    // write is accepted when full, so read and write never collide on stale data.
    assign in_ready = !rst && (r_ram_count != c_FULL_COUNT);
    assign w_push   = in_valid && in_ready;
    assign w_issue  = !rst && (r_ram_count != '0) && (!r_out_valid || out_ready);
    assign w_pop    = r_out_valid && out_ready;

    assign ram_wr_enb  = w_push;
    assign ram_wr_addr = r_wr_ptr;
    assign ram_wr_data = in_data;
    assign ram_rd_enb  = w_issue;
    assign ram_rd_addr = r_rd_ptr;

    assign out_valid = r_out_valid;
    assign out_data  = ram_rd_data;
    assign count     = r_ram_count + (ADDR_WIDTH+1)'(r_out_valid);

    always_comb begin
        w_ram_count_nxt = r_ram_count;
        case ({w_push, w_issue})
            2'b10:   w_ram_count_nxt = r_ram_count + c_ONE_COUNT;
            2'b01:   w_ram_count_nxt = r_ram_count - c_ONE_COUNT;
            default: w_ram_count_nxt = r_ram_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_count <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE_PTR;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ONE_PTR;
            end
            r_ram_count <= w_ram_count_nxt;
            // A fresh issue refills the output stage even when it is popped.
            if (w_issue) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_fifo_ctrl
// Brief    : Self-checking bench for ram_fifo_ctrl with a behavioural RAM and
//            a queue-based FIFO reference model.
// Revision : 1.0
// ============================================================================
module tb_ram_fifo_ctrl;

    localparam int c_AW = 4;
    localparam int c_DEPTH = 16;
    localparam int c_DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [c_DW-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic [c_DW-1:0]   out_data;
    logic [c_AW:0]     count;
    logic              ram_wr_enb;
    logic [c_AW-1:0]   ram_wr_addr;
    logic [c_DW-1:0]   ram_wr_data;
    logic              ram_rd_enb;
    logic [c_AW-1:0]   ram_rd_addr;
    logic [c_DW-1:0]   ram_rd_data;

    int errors = 0;
    int checks = 0;

    ram_fifo_ctrl #(.ADDR_WIDTH(c_AW), .DEPTH(c_DEPTH), .DATA_WIDTH(c_DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .ram_wr_enb  (ram_wr_enb),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_enb  (ram_rd_enb),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural 16x8 RAM with registered read that holds when not enabled.
    logic [c_DW-1:0] mem [c_DEPTH];
    always @(posedge clk) begin
        if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
        if (rst) ram_rd_data <= '0;
        else if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words held in RAM as a queue plus one output slot.
    logic [c_DW-1:0] mq[$];
    bit              mv;
    logic [c_DW-1:0] md;
    int              wn;
    int              rn;
    bit              armed = 1'b0;

    always @(posedge clk) begin
        bit p;
        bit is;
        if (rst) begin
            mq.delete();
            mv = 1'b0;
            wn = 0;
            rn = 0;
            armed = 1'b1;
        end else if (armed) begin
            p  = in_valid && (mq.size() < c_DEPTH);
            is = (mq.size() > 0) && (!mv || out_ready);
            if (is) begin
                md = mq.pop_front();
                mv = 1'b1;
                rn++;
            end else if (mv && out_ready) begin
                mv = 1'b0;
            end
            if (p) begin
                mq.push_back(in_data);
                wn++;
            end
        end
    end

    always @(negedge clk) begin
        bit e_ready;
        bit e_rd;
        if (armed) begin
            e_ready = !rst && (mq.size() < c_DEPTH);
            e_rd    = !rst && (mq.size() > 0) && (!mv || out_ready);
            check("m_in_ready", 32'(in_ready), 32'(e_ready));
            check("m_wr_enb", 32'(ram_wr_enb), 32'(in_valid && e_ready));
            check("m_rd_enb", 32'(ram_rd_enb), 32'(e_rd));
            check("m_out_valid", 32'(out_valid), 32'(mv));
            check("m_count", 32'(count), 32'(mq.size() + int'(mv)));
            if (mv) check("m_out_data", 32'(out_data), 32'(md));
            if (in_valid && e_ready) check("m_wr_addr", 32'(ram_wr_addr), 32'(wn % c_DEPTH));
            if (e_rd) check("m_rd_addr", 32'(ram_rd_addr), 32'(rn % c_DEPTH));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [c_DW-1:0] rx[$];
        bit              prev_hold;
        logic [c_DW-1:0] prev_data;

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset then idle
        @(negedge clk);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wr_enb", 32'(ram_wr_enb), 32'd0);
        check("rst_rd_enb", 32'(ram_rd_enb), 32'd0);

        // Single word with 2-cycle fall-through
        step();
        in_valid = 1'b1;
        in_data = 8'hA5;
        @(negedge clk);
        check("single_wr_enb", 32'(ram_wr_enb), 32'd1);
        check("single_wr_addr", 32'(ram_wr_addr), 32'd0);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("single_rd_enb", 32'(ram_rd_enb), 32'd1);
        check("single_rd_addr", 32'(ram_rd_addr), 32'd0);
        check("single_not_yet", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_data", 32'(out_data), 32'hA5);
        check("single_count", 32'(count), 32'd1);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("single_popped_count", 32'(count), 32'd0);
        check("single_popped_valid", 32'(out_valid), 32'd0);

        // Fill to DEPTH+1 with output blocked, then drain back-to-back
        step();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            @(negedge clk);
            check("fill_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
            check("full_count", 32'(count), 32'd17);
            check("full_wr_enb", 32'(ram_wr_enb), 32'd0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", 32'(out_data), 32'(i));
            step();
        end
        @(negedge clk);
        check("drain_empty_valid", 32'(out_valid), 32'd0);
        check("drain_empty_count", 32'(count), 32'd0);

        // Streaming across two pointer wraps
        step();
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h40 + i);
            out_ready = 1'b1;
            @(negedge clk);
            check("stream_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data), 32'(8'h40 + i - 2));
                check("stream_count", 32'(count), 32'd2);
            end
            step();
        end
        in_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check("stream_tail_valid", 32'(out_valid), 32'd1);
            check("stream_tail_data", 32'(out_data), 32'(8'h40 + 38 + j));
            step();
        end
        @(negedge clk);
        check("stream_end_valid", 32'(out_valid), 32'd0);
        check("stream_end_count", 32'(count), 32'd0);

        // Backpressure with toggling out_ready
        step();
        rx.delete();
        prev_hold = 1'b0;
        prev_data = '0;
        for (int i = 0; i < 28; i++) begin
            in_valid = (i < 8);
            in_data = 8'(8'h3C + i);
            out_ready = (i < 8) ? ((i % 2) == 1) : 1'b1;
            @(negedge clk);
            if (i == 2 || i == 3) begin
                check("bp_head_valid", 32'(out_valid), 32'd1);
                check("bp_head_data", 32'(out_data), 32'h3C);
            end
            if (prev_hold) check("bp_hold", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) rx.push_back(out_data);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            step();
        end
        check("bp_rx_size", 32'(rx.size()), 32'd8);
        for (int k = 0; k < rx.size(); k++) begin
            check("bp_rx_data", 32'(rx[k]), 32'(8'h3C + k));
        end

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data = 8'(8'h90 + i);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_count", 32'(count), 32'd9);
        step();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_wr_enb", 32'(ram_wr_enb), 32'd0);
        check("mid_rst_rd_enb", 32'(ram_rd_enb), 32'd0);
        step();
        rst = 1'b0;
        in_data = 8'h77;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_wait", 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        check("post_rst_head_valid", 32'(out_valid), 32'd1);
        check("post_rst_head_data", 32'(out_data), 32'h77);
        check("post_rst_head_count", 32'(count), 32'd1);

        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that turns the team's single-clock 16x8 RAM into a first-word-fall-through FIFO.
- Sits directly upstream of the RAM and drives its wr_enb/wr_addr/wr_data/rd_enb/rd_addr ports. It consumes the RAM's registered rd_data, which is valid one cycle after rd_enb.
- Producer side and consumer side are valid/ready streams. The RAM output register serves as the FIFO output stage, so the FIFO sustains full throughput.

Parameters:
- ADDR_WIDTH, 4, RAM address width; must match the RAM.
- DEPTH, 16, RAM entries; must equal 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width; must match the RAM.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset. Shared with the RAM's rst.
- in_valid  in  1  producer presents in_data.
- in_ready  out  1  controller can accept a word this cycle.
- in_data  in  DATA_WIDTH  write word.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  DATA_WIDTH  FIFO head; wired directly from ram_rd_data.
- count  out  ADDR_WIDTH+1  total occupancy = ram_count + out_valid, range 0..DEPTH+1.
- ram_wr_enb  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address (wr_ptr).
- ram_wr_data  out  DATA_WIDTH  equals in_data.
- ram_rd_enb  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address (rd_ptr).
- ram_rd_data  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDR_WIDTH bits each; wrap DEPTH-1 -> 0 by natural overflow.
  - ram_count: ADDR_WIDTH+1 bits, number of words held in the RAM.
  - out_valid.
- Reset (rst high at posedge): wr_ptr=0, rd_ptr=0, ram_count=0, out_valid=0, so count=0. While rst is high, in_ready=0, ram_wr_enb=0 and ram_rd_enb=0, combinationally gated. Reset mid-operation discards all contents; RAM contents are not relied on.
- Push:
  - push = in_valid & in_ready.
  - in_ready = !rst & (ram_count != DEPTH).
  - ram_wr_enb = push. On push, wr_ptr increments.
- Issue:
  - issue = !rst & (ram_count != 0) & (!out_valid | out_ready).
  - ram_rd_enb = issue. On issue, rd_ptr increments.
- Pop: pop = out_valid & out_ready.
- out_valid next value:
  - issue -> 1;
  - else pop -> 0;
  - else hold.
- ram_count next value = ram_count + push - issue. Simultaneous push and issue leaves it unchanged.
- out_data = ram_rd_data. The RAM holds rd_data when rd_enb is low, so the head is stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - A push at edge N into an empty FIFO issues a read in cycle N+1; out_valid=1 after edge N+1, i.e. 2-cycle fall-through.
  - Steady state sustains one push and one pop per cycle.
- Read-during-write hazard:
  - A read is only issued from rd_ptr when the registered ram_count is nonzero, so that word was written at an earlier edge.
  - No write is accepted while ram_count==DEPTH, when wr_ptr==rd_ptr.
  - Therefore rd_addr never equals wr_addr with both enables high on stale data.
- Full: ram_count==DEPTH forces in_ready=0. count can then reach DEPTH+1 with the output stage occupied. in_valid while not ready is ignored, not an error.
- Empty: with count==0, out_valid=0, out_data is don't-care, and out_ready is ignored.
- Protocol: a held in_data must be accepted unchanged. Ordering is strictly FIFO across pointer wrap.

Test Plan:
- Reset then idle: count=0, out_valid=0, in_ready=1 from first cycle after rst deasserts; ram_wr_enb=ram_rd_enb=0.
- Single word: push 0xA5 at cycle 0 -> ram_wr_addr=0; ram_rd_enb=1 with ram_rd_addr=0 at cycle 1; out_valid=1 and out_data=0xA5 at cycle 2; pop -> count=0.
- Fill with out_ready=0: push 0x00..0x10 (17 words) -> in_ready drops after count=17; the 18th push (0x11) is refused. Then drain with out_ready=1 -> reads 0x00..0x10 back-to-back, one per cycle, in order.
- Wrap and streaming: push 40 incrementing words with in_valid=out_ready=1 continuously -> pointers wrap twice, output equals input in order, count settles at 1-2, no stall cycles after first fall-through.
- Backpressure hold: head 0x3C with out_ready toggling 0/1 every cycle while pushing -> out_data stays 0x3C until the first pop, and no word is duplicated or lost.
- Reset mid-operation: count=9, assert rst for one cycle -> count=0, out_valid=0; a subsequent push of 0x77 appears as the head 2 cycles later.
